// File: rtl/mux_n1_rr_pkg.sv
// Shared types and constants for the N:1 registered round-robin/directed multiplexer.
package mux_n1_rr_pkg;

  localparam int unsigned DEF_W    = 4;
  localparam int unsigned DEF_N    = 4;
  localparam int unsigned DEF_SELW = 2;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  // Output register occupancy; the encoding doubles as out_valid.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // True when a SELW-bit index can address all n channels.
  function automatic logic sel_width_ok(input int unsigned selw, input int unsigned n);
    return (selw < 32) && (n <= (32'd1 << selw));
  endfunction

endpackage

// File: rtl/mux_n1_rr_if.sv
// Channel-side and output-side handshake bundle for mux_n1_rr.
interface mux_n1_rr_if #(
  parameter int unsigned W    = 4,
  parameter int unsigned N    = 4,
  parameter int unsigned SELW = 2
) ();

  logic              mode;
  logic [SELW-1:0]   sel;
  logic [N*W-1:0]    in_data;
  logic [N-1:0]      in_valid;
  logic [N-1:0]      in_ready;
  logic [W-1:0]      out_data;
  logic [SELW-1:0]   out_src;
  logic              out_valid;
  logic              out_ready;

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_src, out_valid
  );

  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_src, out_valid
  );

endinterface

// File: rtl/mux_n1_rr_rr_pick.sv
// Combinational rotating-priority picker: first valid index at or after ptr, wrapping mod N.
// ptr is expected to be below N.
module mux_n1_rr_rr_pick #(
  parameter int unsigned N    = 4,
  parameter int unsigned SELW = 2
) (
  input  logic [N-1:0]    valid,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] idx,
  output logic            any
);

  logic [N-1:0] w_rot;
  int unsigned  w_off;
  int unsigned  w_sum;

  // Rotate so bit k is channel (ptr+k) mod N, then take the lowest set offset.
  always_comb begin
    w_rot = N'({valid, valid} >> ptr);
    w_off = 0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = 32'(k);
    end
    w_sum = w_off + 32'(ptr);
    if (w_sum >= N) w_sum = w_sum - N;
    idx = SELW'(w_sum);
    any = |valid;
  end

endmodule

// File: rtl/mux_n1_rr.sv
// N-input, W-bit registered multiplexer/arbiter with directed and round-robin grant modes.
// One output register stage; accepts a new word whenever the register is empty or draining.
module mux_n1_rr
  import mux_n1_rr_pkg::*;
#(
  parameter int unsigned W    = DEF_W,
  parameter int unsigned N    = DEF_N,
  parameter int unsigned SELW = DEF_SELW
) (
  input  logic        clk,
  input  logic        rst,
  mux_n1_rr_if.slave  bus
);

  generate
    if (!sel_width_ok(SELW, N)) begin : g_bad_selw
      $error("mux_n1_rr: SELW too narrow for N");
    end
  endgenerate

  state_e          r_state;
  state_e          w_state_nxt;
  logic [W-1:0]    r_data;
  logic [SELW-1:0] r_src;
  logic [SELW-1:0] r_ptr;

  logic [SELW-1:0] w_rr_idx;
  logic            w_rr_any;
  logic [N-1:0]    w_dir_vsh;
  logic            w_dir_ok;
  logic [SELW-1:0] w_grant;
  logic            w_gvalid;
  logic [W-1:0]    w_gdata;
  logic            w_load_en;
  logic            w_xfer;
  logic [SELW-1:0] w_ptr_nxt;

  mux_n1_rr_rr_pick #(
    .N    (N),
    .SELW (SELW)
  ) u_pick (
    .valid (bus.in_valid),
    .ptr   (r_ptr),
    .idx   (w_rr_idx),
    .any   (w_rr_any)
  );

  // Grant mode mux; an out-of-range directed select never grants.
  always_comb begin
    w_dir_vsh = bus.in_valid >> bus.sel;
    w_dir_ok  = (32'(bus.sel) < N) && w_dir_vsh[0];
    if (bus.mode == MODE_RR) begin
      w_grant  = w_rr_idx;
      w_gvalid = w_rr_any;
    end else begin
      w_grant  = bus.sel;
      w_gvalid = w_dir_ok;
    end
  end

  always_comb begin
    w_gdata = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (w_grant == SELW'(i)) w_gdata = bus.in_data[i*W +: W];
    end
  end

  assign w_load_en = (r_state == ST_EMPTY) || bus.out_ready;
  assign w_xfer    = w_load_en && w_gvalid && !rst;
  assign w_ptr_nxt = (32'(w_grant) == N - 1) ? '0 : w_grant + SELW'(1);

  always_comb begin
    bus.in_ready = '0;
    for (int i = 0; i < int'(N); i++) begin
      bus.in_ready[i] = w_xfer && (w_grant == SELW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_EMPTY;
    else     r_state <= w_state_nxt;
  end

  // A refill on the same edge as a drain keeps the register full.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_EMPTY: if (w_xfer) w_state_nxt = ST_FULL;
      ST_FULL:  if (!w_xfer && bus.out_ready) w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
      r_src  <= '0;
      r_ptr  <= '0;
    end else if (w_xfer) begin
      r_data <= w_gdata;
      r_src  <= w_grant;
      r_ptr  <= w_ptr_nxt;
    end
  end

  assign bus.out_valid = (r_state == ST_FULL);
  assign bus.out_data  = r_data;
  assign bus.out_src   = r_src;

endmodule

// File: tb/tb_mux_n1_rr.sv
// Self-checking bench for mux_n1_rr: directed vector table, N=3 corner sequence, random run vs model.
module tb_mux_n1_rr;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux_n1_rr_if #(.W(4), .N(4), .SELW(2)) b4 ();
  mux_n1_rr_if #(.W(4), .N(3), .SELW(2)) b3 ();

  mux_n1_rr #(.W(4), .N(4), .SELW(2)) u_dut4 (.clk(clk), .rst(rst), .bus(b4.slave));
  mux_n1_rr #(.W(4), .N(3), .SELW(2)) u_dut3 (.clk(clk), .rst(rst), .bus(b3.slave));

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        rst;
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  iv;
    logic [15:0] din;
    logic        ordy;
    logic [3:0]  e_rdy;
    logic        e_val;
    logic [3:0]  e_dat;
    logic [1:0]  e_src;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic m, input logic [1:0] s,
                              input logic [3:0] iv, input logic [15:0] d, input logic o,
                              input logic [3:0] er, input logic ev, input logic [3:0] ed,
                              input logic [1:0] es);
    vec_t v;
    v.rst = r; v.mode = m; v.sel = s; v.iv = iv; v.din = d; v.ordy = o;
    v.e_rdy = er; v.e_val = ev; v.e_dat = ed; v.e_src = es;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, want, $time);
    end
  endtask

  task automatic drive4(input logic r, input logic m, input logic [1:0] s,
                        input logic [3:0] iv, input logic [15:0] d, input logic o);
    rst = r; b4.mode = m; b4.sel = s; b4.in_valid = iv; b4.in_data = d; b4.out_ready = o;
  endtask

  task automatic step3(input string nm, input logic r, input logic m, input logic [1:0] s,
                       input logic [2:0] iv, input logic [11:0] d, input logic o,
                       input logic [2:0] er, input logic ev, input logic [3:0] ed,
                       input logic [1:0] es);
    @(negedge clk);
    rst = r; b3.mode = m; b3.sel = s; b3.in_valid = iv; b3.in_data = d; b3.out_ready = o;
    #1;
    chk({nm, "_rdy"}, 32'(b3.in_ready), 32'(er));
    @(posedge clk); #1;
    chk({nm, "_val"}, 32'(b3.out_valid), 32'(ev));
    chk({nm, "_dat"}, 32'(b3.out_data), 32'(ed));
    chk({nm, "_src"}, 32'(b3.out_src), 32'(es));
  endtask

  // Reference state: held word, its source, and the round-robin start point.
  int m_val, m_dat, m_src, m_ptr;

  initial begin
    vec_t        vt[18];
    logic [15:0] dd;
    logic [3:0]  er;
    logic        r, m, o, gv;
    logic [1:0]  s;
    logic [3:0]  iv;
    int          g, bestd, d;

    dd = 16'h5A31;
    vt[0]  = mk(1, 0, 0, 4'b1111, dd,       1, 4'b0000, 0, 4'h0, 0);
    vt[1]  = mk(1, 0, 0, 4'b1111, dd,       1, 4'b0000, 0, 4'h0, 0);
    vt[2]  = mk(0, 0, 2, 4'b0100, dd,       1, 4'b0100, 1, 4'hA, 2);
    vt[3]  = mk(0, 0, 1, 4'b0100, dd,       1, 4'b0000, 0, 4'hA, 2);
    vt[4]  = mk(1, 1, 0, 4'b1111, dd,       1, 4'b0000, 0, 4'h0, 0);
    vt[5]  = mk(0, 1, 0, 4'b1111, dd,       1, 4'b0001, 1, 4'h1, 0);
    vt[6]  = mk(0, 1, 0, 4'b1111, dd,       1, 4'b0010, 1, 4'h3, 1);
    vt[7]  = mk(0, 1, 0, 4'b1111, dd,       1, 4'b0100, 1, 4'hA, 2);
    vt[8]  = mk(0, 1, 0, 4'b1111, dd,       1, 4'b1000, 1, 4'h5, 3);
    vt[9]  = mk(0, 1, 0, 4'b1111, dd,       1, 4'b0001, 1, 4'h1, 0);
    vt[10] = mk(0, 0, 3, 4'b1000, dd,       1, 4'b1000, 1, 4'h5, 3);
    vt[11] = mk(0, 1, 0, 4'b1111, 16'hFFFF, 0, 4'b0000, 1, 4'h5, 3);
    vt[12] = mk(0, 0, 1, 4'b0010, 16'hFFFF, 0, 4'b0000, 1, 4'h5, 3);
    vt[13] = mk(0, 1, 0, 4'b0110, 16'hFFFF, 0, 4'b0000, 1, 4'h5, 3);
    vt[14] = mk(0, 1, 0, 4'b0010, dd,       1, 4'b0010, 1, 4'h3, 1);
    vt[15] = mk(0, 1, 0, 4'b0000, dd,       0, 4'b0000, 1, 4'h3, 1);
    vt[16] = mk(1, 1, 0, 4'b1111, dd,       0, 4'b0000, 0, 4'h0, 0);
    vt[17] = mk(0, 0, 3, 4'b0000, dd,       0, 4'b0000, 0, 4'h0, 0);

    drive4(1, 0, 0, 4'b1111, dd, 1);
    b3.mode = 0; b3.sel = 0; b3.in_valid = '0; b3.in_data = '0; b3.out_ready = 1'b1;

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive4(vt[i].rst, vt[i].mode, vt[i].sel, vt[i].iv, vt[i].din, vt[i].ordy);
      #1;
      chk($sformatf("vec%0d_rdy", i), 32'(b4.in_ready), 32'(vt[i].e_rdy));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_val", i), 32'(b4.out_valid), 32'(vt[i].e_val));
      chk($sformatf("vec%0d_dat", i), 32'(b4.out_data), 32'(vt[i].e_dat));
      chk($sformatf("vec%0d_src", i), 32'(b4.out_src), 32'(vt[i].e_src));
    end

    // N=3: pointer wraps from the last channel back to 0; out-of-range select; reset while full.
    drive4(0, 0, 0, 4'b0000, dd, 1);
    step3("n3_rst",     1, 1, 0, 3'b111, 12'h769, 1, 3'b000, 0, 4'h0, 0);
    step3("n3_only2",   0, 1, 0, 3'b100, 12'h769, 1, 3'b100, 1, 4'h7, 2);
    step3("n3_wrap",    0, 1, 0, 3'b011, 12'h769, 1, 3'b001, 1, 4'h9, 0);
    step3("n3_sel_oob", 0, 0, 3, 3'b111, 12'h769, 1, 3'b000, 0, 4'h9, 0);
    step3("n3_dir2",    0, 0, 2, 3'b111, 12'h769, 1, 3'b100, 1, 4'h7, 2);
    step3("n3_rstfull", 1, 1, 0, 3'b111, 12'h769, 0, 3'b000, 0, 4'h0, 0);
    b3.in_valid = '0;

    // Random run on N=4 against the reference model, starting from reset.
    m_val = 0; m_dat = 0; m_src = 0; m_ptr = 0;
    for (int c = 0; c < 400; c++) begin
      r  = (c == 0) || ($urandom_range(0, 39) == 0);
      m  = 1'($urandom);
      s  = 2'($urandom);
      iv = 4'($urandom) & 4'($urandom | 32'($urandom_range(0, 1)) * 32'hF);
      dd = 16'($urandom);
      o  = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      drive4(r, m, s, iv, dd, o);

      if (m == 1'b0) begin
        g  = int'(s);
        gv = iv[s];
      end else begin
        bestd = 99; g = 0;
        for (int i = 0; i < 4; i++) begin
          if (iv[i]) begin
            d = (i - m_ptr + 4) % 4;
            if (d < bestd) begin bestd = d; g = i; end
          end
        end
        gv = (bestd != 99);
      end
      er = (!r && (m_val == 0 || o) && gv) ? 4'(1 << g) : 4'b0000;

      #1;
      chk($sformatf("rnd%0d_rdy", c), 32'(b4.in_ready), 32'(er));

      if (r) begin
        m_val = 0; m_dat = 0; m_src = 0; m_ptr = 0;
      end else if (er != 4'b0000) begin
        m_val = 1; m_dat = int'(dd[g*4 +: 4]); m_src = g; m_ptr = (g + 1) % 4;
      end else if (m_val != 0 && o) begin
        m_val = 0;
      end

      @(posedge clk); #1;
      chk($sformatf("rnd%0d_val", c), 32'(b4.out_valid), 32'(m_val));
      chk($sformatf("rnd%0d_dat", c), 32'(b4.out_data), 32'(m_dat));
      chk($sformatf("rnd%0d_src", c), 32'(b4.out_src), 32'(m_src));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
